// File: rtl/load_store_unit.sv
// Load/store stage: one outstanding data-memory access per core,
// with load write-back into the register file and a bounded wait.
module load_store_unit #(
  parameter int CORE_ID        = 0,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [1:0]            dest_reg,
  output logic                  mem_read_valid,
  output logic [DATA_WIDTH-1:0] mem_read_address,
  input  logic                  mem_read_ready,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_write_valid,
  output logic [DATA_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_write_ready,
  output logic                  rf_write_en,
  output logic [1:0]            rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [7:0]            dbg_core_id
);

  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam int TLIM   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                state;
  state_t                state_n;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rf_data_q;
  logic [1:0]            dest_q;
  logic                  op_q;
  logic                  err_q;
  logic                  start;
  logic                  hs;
  logic                  tmo;
  logic                  in_req;
  logic                  in_rsp;

  assign in_req = (state == REQUEST);
  assign in_rsp = (state == RESPOND);
  assign start  = issue & (is_load | is_store);
  assign hs     = in_req & (op_q ? mem_read_ready : mem_write_ready);
  assign tmo    = TMO_EN & in_req & ~hs & (cnt == CW'(TLIM));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = REQUEST;
      REQUEST: if (hs || tmo) state_n = RESPOND;
      RESPOND: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      dest_q    <= '0;
      op_q      <= 1'b0;
      err_q     <= 1'b0;
      rf_data_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        addr_q <= addr;
        data_q <= store_data;
        dest_q <= dest_reg;
        op_q   <= is_load;
        err_q  <= 1'b0;
        cnt    <= '0;
      end
      // handshake beats a timeout landing in the same cycle
      if (hs) begin
        err_q <= 1'b0;
        if (op_q) rf_data_q <= mem_read_data;
      end else if (tmo) begin
        err_q <= 1'b1;
      end else if (in_req) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign mem_read_valid    = in_req & op_q;
  assign mem_write_valid   = in_req & ~op_q;
  assign mem_read_address  = mem_read_valid ? addr_q : '0;
  assign mem_write_address = mem_write_valid ? addr_q : '0;
  assign mem_write_data    = mem_write_valid ? data_q : '0;

  assign done          = in_rsp;
  assign error         = in_rsp & err_q;
  assign rf_write_en   = in_rsp & op_q & ~err_q;
  assign rf_write_addr = in_rsp ? dest_q : 2'd0;
  assign rf_write_data = rf_data_q;
  assign busy          = (state != IDLE);
  assign dbg_core_id   = 8'(CORE_ID);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: random accesses with
// a transaction-level model of waits, timeouts and write-back.
module tb_load_store_unit;

  localparam int TMO = 4;
  localparam int CID = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue, is_load, is_store;
  logic [7:0] addr, store_data;
  logic [1:0] dest_reg;
  logic       mem_read_valid, mem_read_ready;
  logic [7:0] mem_read_address, mem_read_data;
  logic       mem_write_valid, mem_write_ready;
  logic [7:0] mem_write_address, mem_write_data;
  logic       rf_write_en;
  logic [1:0] rf_write_addr;
  logic [7:0] rf_write_data;
  logic       busy, done, error;
  logic [7:0] dbg_core_id;

  load_store_unit #(
    .CORE_ID(CID), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .issue(issue), .is_load(is_load), .is_store(is_store),
    .addr(addr), .store_data(store_data), .dest_reg(dest_reg),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .mem_write_ready(mem_write_ready),
    .rf_write_en(rf_write_en),
    .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .busy(busy), .done(done), .error(error),
    .dbg_core_id(dbg_core_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         ld;
    logic [7:0] a;
    logic [7:0] sd;
    logic [7:0] rd;
    logic [1:0] dst;
    int         w;
    bit         err;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  int         vcnt = 0;
  bit         prev_valid = 0;
  logic [7:0] last_rf = '0;
  int         cur_w = 0;
  logic [7:0] cur_rd = '0;
  int         wcnt = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // memory: ready after cur_w wait cycles of a pending request
  always @(negedge clk) begin
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = 8'($urandom);
    if (mem_read_valid || mem_write_valid) begin
      if (wcnt == cur_w) begin
        mem_read_ready  = 1'b1;
        mem_write_ready = 1'b1;
        mem_read_data   = cur_rd;
      end
      wcnt++;
    end else begin
      wcnt = 0;
    end
  end

  // monitor: checks requests and completions against queued expectations
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (mem_read_valid || mem_write_valid) begin
        if (q.size() == 0) begin
          chk("req_unexpected", 1, 0);
        end else begin
          e = q[0];
          chk("req_kind", 32'(mem_read_valid), 32'(e.ld));
          chk("req_both", 32'(mem_read_valid & mem_write_valid), 0);
          if (e.ld) begin
            chk("rd_addr", 32'(mem_read_address), 32'(e.a));
          end else begin
            chk("wr_addr", 32'(mem_write_address), 32'(e.a));
            chk("wr_data", 32'(mem_write_data), 32'(e.sd));
          end
          vcnt++;
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          chk("error", 32'(error), 32'(e.err));
          chk("rf_we", 32'(rf_write_en), 32'(e.ld && !e.err));
          if (e.ld && !e.err) begin
            chk("rf_addr", 32'(rf_write_addr), 32'(e.dst));
            last_rf = e.rd;
          end
          chk("rf_data", 32'(rf_write_data), 32'(last_rf));
          chk("valid_cycles", vcnt, e.err ? TMO : e.w + 1);
          chk("done_after_req", 32'(prev_valid), 1);
          vcnt = 0;
        end
      end
      prev_valid = mem_read_valid | mem_write_valid;
    end
  end

  task automatic noise();
    issue      = 1'($urandom);
    is_load    = 1'($urandom);
    is_store   = 1'($urandom);
    addr       = 8'($urandom);
    store_data = 8'($urandom);
    dest_reg   = 2'($urandom);
  endtask

  task automatic quiet();
    issue    = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
  endtask

  task automatic do_access(input bit ld, input bit st,
                           input logic [7:0] a, input logic [7:0] sd,
                           input logic [7:0] rd, input logic [1:0] dst,
                           input int w, input bit nz);
    exp_t e;
    int   n;
    e.ld  = ld;
    e.a   = a;
    e.sd  = sd;
    e.rd  = rd;
    e.dst = dst;
    e.w   = w;
    e.err = (w >= TMO);
    q.push_back(e);
    cur_w      = w;
    cur_rd     = rd;
    issue      = 1'b1;
    is_load    = ld;
    is_store   = st;
    addr       = a;
    store_data = sd;
    dest_reg   = dst;
    @(negedge clk);
    quiet();
    chk("busy_after_issue", 32'(busy), 1);
    n = 0;
    while (busy && n < 40) begin
      if (nz) noise();
      @(negedge clk);
      n++;
    end
    quiet();
    chk("access_bounded", 32'(n < 40), 1);
    chk("busy_len", n, (e.err ? TMO : w + 1) + 1);
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask

  task automatic check_idle_zero(string tag);
    chk({tag, "_rv"}, 32'(mem_read_valid), 0);
    chk({tag, "_ra"}, 32'(mem_read_address), 0);
    chk({tag, "_wv"}, 32'(mem_write_valid), 0);
    chk({tag, "_wa"}, 32'(mem_write_address), 0);
    chk({tag, "_wd"}, 32'(mem_write_data), 0);
    chk({tag, "_we"}, 32'(rf_write_en), 0);
    chk({tag, "_wadr"}, 32'(rf_write_addr), 0);
    chk({tag, "_wdat"}, 32'(rf_write_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(error), 0);
  endtask

  initial begin
    reset = 1'b1;
    quiet();
    addr       = '0;
    store_data = '0;
    dest_reg   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");
    chk("core_id", 32'(dbg_core_id), CID);

    do_access(1, 0, 8'h05, 8'h00, 8'hA7, 2'd2, 3, 0);
    do_access(0, 1, 8'h03, 8'h5C, 8'h00, 2'd0, 0, 0);
    do_access(1, 0, 8'h11, 8'h00, 8'h3C, 2'd1, 50, 0);
    do_access(1, 1, 8'h22, 8'h99, 8'h6E, 2'd3, 1, 1);

    issue = 1'b1;
    @(negedge clk);
    quiet();
    chk("neither_busy", 32'(busy), 0);

    // reset while a load waits in REQUEST
    q.push_back('{ld: 1, a: 8'h40, sd: 8'h00, rd: 8'h00,
                  dst: 2'd1, w: 100, err: 1});
    cur_w    = 100;
    issue    = 1'b1;
    is_load  = 1'b1;
    addr     = 8'h40;
    dest_reg = 2'd1;
    @(negedge clk);
    quiet();
    @(negedge clk);
    chk("pre_reset_rv", 32'(mem_read_valid), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    vcnt       = 0;
    prev_valid = 0;
    last_rf    = '0;
    check_idle_zero("midreset");
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_done", 32'(done | rf_write_en), 0);
    end
    do_access(1, 0, 8'h41, 8'h00, 8'hC3, 2'd1, 0, 0);

    for (int i = 0; i < 150; i++) begin
      int         r;
      logic [7:0] a, sd, rd;
      logic [1:0] d;
      r  = $urandom_range(0, 9);
      a  = 8'($urandom);
      sd = 8'($urandom);
      rd = 8'($urandom);
      d  = 2'($urandom);
      if (r == 0) begin
        issue = 1'b1;
        addr  = a;
        @(negedge clk);
        quiet();
        chk("rand_neither", 32'(busy), 0);
      end else begin
        do_access(r <= 5, r == 1 || r > 5, a, sd, rd, d,
                  $urandom_range(0, 5), 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
